// File: rtl/dso_capture_mc.sv
// Multi-channel decimating edge-trigger capture core. Holds one circular frame
// per channel, and reads back by logical address, where rd_addr == pre_depth is the trigger sample.
module dso_capture_mc #(
    parameter int CH   = 2,
    parameter int DW   = 8,
    parameter int AW   = 10,
    parameter int DECW = 10,
    localparam int SW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ad_valid,
    input  logic [CH*DW-1:0] ad_data,
    input  logic            wave_run,
    input  logic [1:0]      trig_mode,
    input  logic [SW-1:0]   trig_src,
    input  logic [DW-1:0]   trig_level,
    input  logic            trig_edge,
    input  logic [AW-1:0]   pre_depth,
    input  logic [DECW-1:0] deci_rate,
    input  logic [23:0]     auto_timeout,
    input  logic            rd_en,
    input  logic [SW-1:0]   rd_ch,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    input  logic            rd_done,
    output logic            armed,
    output logic            triggered,
    output logic            capture_done,
    output logic            auto_trig
);
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_nx_s;
    logic [1:0]      mode_r;
    logic [SW-1:0]   src_r;
    logic [DW-1:0]   level_r, prev_r, cur_s;
    logic            edge_r, prev_vld_r, single_blk_r;
    logic [AW-1:0]   pre_r, wr_ptr_r, trig_ptr_r, phys_s;
    logic [DECW-1:0] deci_m1_r, deci_cnt_r;
    logic [23:0]     tmo_r, tmo_cnt_r;
    logic [AW:0]     post_cnt_r, post_need_s, post_cnt_nx_s;
    logic            wr_state_s, de_s, edge_hit_s, tmo_hit_s, trig_s, arm_s;
    logic [SW-1:0]   rd_sel_s;
    logic            armed_r, triggered_r, done_r, auto_r;
    logic [DW-1:0]   rd_data_r;
    logic [DW-1:0]   mem_r [CH][2**AW];

    // Decimation strobe, trigger detection and read address mapping
    always_comb begin
        wr_state_s    = ((state_r == ST_PRE) && (pre_r != '0)) ||
                        (state_r == ST_ARMED) || (state_r == ST_POST);
        de_s          = wr_state_s && ad_valid && (deci_cnt_r == '0);
        cur_s         = ad_data[int'(src_r)*DW +: DW];
        edge_hit_s    = prev_vld_r && (edge_r ? ((prev_r >= level_r) && (cur_s < level_r))
                                              : ((prev_r < level_r) && (cur_s >= level_r)));
        tmo_hit_s     = (mode_r == 2'd0) && (tmo_cnt_r == tmo_r);
        trig_s        = (state_r == ST_ARMED) && de_s && (edge_hit_s || tmo_hit_s);
        post_need_s   = DEPTH_V - {1'b0, pre_r};
        post_cnt_nx_s = post_cnt_r + (AW+1)'(1);
        phys_s        = trig_ptr_r - pre_r + rd_addr;
        if (int'(rd_ch) < CH) begin
            rd_sel_s = rd_ch;
        end else begin
            rd_sel_s = '0;
        end
    end

    // Next-state logic; arming is any entry into PRE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wave_run && !single_blk_r) state_nx_s = ST_PRE;
                else                           state_nx_s = ST_IDLE;
            end
            ST_PRE: begin
                if (!wave_run)                                state_nx_s = ST_IDLE;
                else if (pre_r == '0)                         state_nx_s = ST_ARMED;
                else if (de_s && (wr_ptr_r == pre_r - AW'(1))) state_nx_s = ST_ARMED;
                else                                          state_nx_s = ST_PRE;
            end
            ST_ARMED: begin
                if (!wave_run)                   state_nx_s = ST_IDLE;
                else if (trig_s && (post_need_s == (AW+1)'(1))) state_nx_s = ST_DONE;
                else if (trig_s)                 state_nx_s = ST_POST;
                else                             state_nx_s = ST_ARMED;
            end
            ST_POST: begin
                if (!wave_run)                                   state_nx_s = ST_IDLE;
                else if (de_s && (post_cnt_nx_s == post_need_s)) state_nx_s = ST_DONE;
                else                                             state_nx_s = ST_POST;
            end
            ST_DONE: begin
                if (rd_done && wave_run && (mode_r != 2'd2)) state_nx_s = ST_PRE;
                else if (rd_done)                            state_nx_s = ST_IDLE;
                else                                         state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
        arm_s = (state_nx_s == ST_PRE) && (state_r != ST_PRE);
    end

    // Control state, latched configuration, counters and registered status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            mode_r       <= 2'd0;
            src_r        <= '0;
            level_r      <= '0;
            edge_r       <= 1'b0;
            pre_r        <= '0;
            deci_m1_r    <= '0;
            tmo_r        <= 24'd0;
            deci_cnt_r   <= '0;
            wr_ptr_r     <= '0;
            prev_r       <= '0;
            prev_vld_r   <= 1'b0;
            tmo_cnt_r    <= 24'd0;
            post_cnt_r   <= '0;
            trig_ptr_r   <= '0;
            single_blk_r <= 1'b0;
            armed_r      <= 1'b0;
            triggered_r  <= 1'b0;
            done_r       <= 1'b0;
            auto_r       <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (arm_s) begin
                mode_r     <= trig_mode;
                src_r      <= (int'(trig_src) < CH) ? trig_src : '0;
                level_r    <= trig_level;
                edge_r     <= trig_edge;
                pre_r      <= pre_depth;   // AW bits can never exceed DEPTH-1
                deci_m1_r  <= (deci_rate == '0) ? '0 : deci_rate - DECW'(1);
                tmo_r      <= auto_timeout;
                deci_cnt_r <= '0;
                wr_ptr_r   <= '0;
                prev_vld_r <= 1'b0;
                tmo_cnt_r  <= 24'd0;
                auto_r     <= 1'b0;
            end else begin
                if (wr_state_s && ad_valid) begin
                    deci_cnt_r <= (deci_cnt_r == deci_m1_r) ? '0 : deci_cnt_r + DECW'(1);
                end
                if (de_s) begin
                    wr_ptr_r   <= wr_ptr_r + AW'(1);
                    prev_r     <= cur_s;
                    prev_vld_r <= 1'b1;
                end
                if (de_s && (state_r == ST_ARMED)) begin
                    tmo_cnt_r <= tmo_cnt_r + 24'd1;
                end
                if (trig_s) begin
                    trig_ptr_r <= wr_ptr_r;
                    post_cnt_r <= (AW+1)'(1);
                    auto_r     <= tmo_hit_s && !edge_hit_s;
                end else if (de_s && (state_r == ST_POST)) begin
                    post_cnt_r <= post_cnt_nx_s;
                end
            end
            // single mode needs wave_run to drop before it may re-arm
            if (!wave_run) begin
                single_blk_r <= 1'b0;
            end else if ((state_r == ST_DONE) && rd_done && (mode_r == 2'd2)) begin
                single_blk_r <= 1'b1;
            end
            armed_r     <= (state_nx_s == ST_PRE) || (state_nx_s == ST_ARMED);
            triggered_r <= (state_nx_s == ST_POST) || (state_nx_s == ST_DONE);
            done_r      <= (state_nx_s == ST_DONE);
        end
    end

    // Sample RAM: every channel written in lockstep on each decimated sample
    always_ff @(posedge clk) begin
        if (!rst && de_s) begin
            for (int c = 0; c < CH; c++) begin
                mem_r[c][wr_ptr_r] <= ad_data[c*DW +: DW];
            end
        end
    end

    // Registered readback, holds while rd_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_sel_s][phys_s];
        end
    end

    assign rd_data      = rd_data_r;
    assign armed        = armed_r;
    assign triggered    = triggered_r;
    assign capture_done = done_r;
    assign auto_trig    = auto_r;
endmodule

// File: tb/tb_dso_capture_mc.sv
// Directed bench for dso_capture_mc: sawtooth, constant, square and single-mode
// captures with hand-computed readback values.
module tb_dso_capture_mc;
    logic        clk, rst, ad_valid, wave_run, trig_edge, rd_en, rd_done;
    logic [15:0] ad_data;
    logic [1:0]  trig_mode;
    logic        trig_src, rd_ch;
    logic [7:0]  trig_level, rd_data;
    logic [9:0]  pre_depth, deci_rate, rd_addr;
    logic [23:0] auto_timeout;
    logic        armed, triggered, capture_done, auto_trig;

    int n, nd, tests, fails, pat_sel;
    logic [7:0] v0, v1;

    dso_capture_mc #(.CH(2), .DW(8), .AW(10), .DECW(10)) dut (
        .clk(clk), .rst(rst), .ad_valid(ad_valid), .ad_data(ad_data),
        .wave_run(wave_run), .trig_mode(trig_mode), .trig_src(trig_src),
        .trig_level(trig_level), .trig_edge(trig_edge), .pre_depth(pre_depth),
        .deci_rate(deci_rate), .auto_timeout(auto_timeout), .rd_en(rd_en),
        .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
        .armed(armed), .triggered(triggered), .capture_done(capture_done),
        .auto_trig(auto_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int k);
        logic [7:0] a, b;
        a = 8'(k);
        case (pat_sel)
            0:       b = 8'(k + 64);
            1:       begin a = 8'd50; b = 8'd50; end
            default: b = (((k / 8) % 2) == 0) ? 8'd200 : 8'd20;
        endcase
        return {b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        ad_valid = 1'b1;
        ad_data  = pat(n);
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && capture_done !== 1'b1; i++) step();
        check("done_reached", capture_done, 1);
    endtask

    task automatic rd(input logic ch, input logic [9:0] addr, output logic [7:0] val);
        rd_en = 1'b1; rd_ch = ch; rd_addr = addr;
        step();
        rd_en = 1'b0;
        val = rd_data;
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; n = 0; pat_sel = 0;
        rst = 1'b1; ad_valid = 1'b0; ad_data = 16'd0; wave_run = 1'b0;
        trig_mode = 2'd0; trig_src = 1'b0; trig_level = 8'd128; trig_edge = 1'b0;
        pre_depth = 10'd0; deci_rate = 10'd1; auto_timeout = 24'hFFFFFF;
        rd_en = 1'b0; rd_ch = 1'b0; rd_addr = 10'd0; rd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", capture_done, 0);
        check("rst_auto", auto_trig, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;

        // S1: auto, pre 0, rising 128 on sawtooth
        wave_run = 1'b1; n = 0;
        wait_done(3000);
        check("s1_done_time", n, 1152);
        check("s1_triggered", triggered, 1);
        check("s1_armed", armed, 0);
        check("s1_auto", auto_trig, 0);
        rd(1'b0, 10'd0, v0);    check("s1_ch0_a0", v0, 128);
        rd(1'b0, 10'd1023, v0); check("s1_ch0_a1023", v0, 127);
        rd(1'b1, 10'd0, v0);    check("s1_ch1_a0", v0, 192);
        rd_addr = 10'd5; step(); check("s1_rd_hold", rd_data, 192);

        // S2: pre_depth 100, re-armed through rd_done
        pre_depth = 10'd100;
        pulse_done();
        check("s2_armed", armed, 1);
        check("s2_done_clr", capture_done, 0);
        wait_done(3000);
        rd(1'b0, 10'd100, v0); check("s2_a100", v0, 128);
        rd(1'b0, 10'd99, v0);  check("s2_a99", v0, 127);
        rd(1'b0, 10'd0, v0);   check("s2_a0", v0, 28);

        // S3: pre 1023, timeout 0; sample in the rd_done cycle must be skipped
        pre_depth = 10'd1023; auto_timeout = 24'd0;
        if ((n % 256) == 128) step();
        nd = n;
        pulse_done();
        wait_done(3000);
        check("s3_done_time", n, nd + 1025);
        check("s3_auto", auto_trig, 1);
        rd(1'b0, 10'd0, v0);    check("s3_a0", v0, (nd + 1) % 256);
        rd(1'b0, 10'd1023, v0); check("s3_a1023", v0, nd % 256);

        // S4: normal mode on constant 50 never triggers
        pat_sel = 1; trig_mode = 2'd1; pre_depth = 10'd0; auto_timeout = 24'd500;
        pulse_done();
        repeat (2000) step();
        check("s4_no_done", capture_done, 0);
        check("s4_no_trig", triggered, 0);
        check("s4_armed", armed, 1);
        check("s4_auto_clr", auto_trig, 0);
        wave_run = 1'b0; step();
        check("s4_stop_armed", armed, 0);
        trig_mode = 2'd0; wave_run = 1'b1; n = 0;
        wait_done(3000);
        check("s4_auto_time", n, 1526);
        check("s4_auto", auto_trig, 1);
        check("s4_triggered", triggered, 1);

        // S5: decimate by 4, falling edge on ch1 square wave
        pat_sel = 2; trig_mode = 2'd1; trig_src = 1'b1; trig_edge = 1'b1;
        deci_rate = 10'd4; pre_depth = 10'd10;
        pulse_done();
        wait_done(6000);
        rd(1'b1, 10'd10, v0); check("s5_trig", v0, 20);
        rd(1'b1, 10'd9, v0);  check("s5_m1", v0, 200);
        rd(1'b1, 10'd8, v0);  check("s5_m2", v0, 200);
        rd(1'b1, 10'd7, v0);  check("s5_m3", v0, 20);
        rd(1'b1, 10'd11, v0); check("s5_p1", v0, 20);
        rd(1'b1, 10'd12, v0); check("s5_p2", v0, 200);
        rd(1'b0, 10'd10, v0);
        rd(1'b0, 10'd11, v1);
        check("s5_ch0_step", 8'(v1 - v0), 4);
        check("s5_ch0_phase", ((v0 % 16) >= 8) && ((v0 % 16) < 12), 1);

        // S6: single mode stays idle until wave_run toggles
        pat_sel = 0; trig_mode = 2'd2; trig_src = 1'b0; trig_edge = 1'b0;
        deci_rate = 10'd1; pre_depth = 10'd0;
        pulse_done();
        wait_done(3000);
        rd(1'b0, 10'd0, v0); check("s6_a0", v0, 128);
        pulse_done();
        repeat (3) step();
        check("s6_idle_armed", armed, 0);
        check("s6_idle_done", capture_done, 0);
        check("s6_idle_trig", triggered, 0);
        wave_run = 1'b0; step();
        check("s6_low_armed", armed, 0);
        wave_run = 1'b1; step();
        check("s6_rearm", armed, 1);

        // S7: reset pulse during POST
        for (int i = 0; i < 1000 && triggered !== 1'b1; i++) step();
        check("s7_in_post", {triggered, capture_done}, 2'b10);
        rst = 1'b1; step(); rst = 1'b0;
        check("s7_armed", armed, 0);
        check("s7_triggered", triggered, 0);
        check("s7_done", capture_done, 0);
        check("s7_auto", auto_trig, 0);
        check("s7_rd_data", rd_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dso_capture_mc.md
# dso_capture_mc

Multi-channel, parametrised trigger-and-capture core for the DSO path, the next generation of the single-channel capture inside `dso_top`. It decimates CH parallel ADC channels, detects an edge trigger on a selectable channel with programmable pre-trigger depth and auto/normal/single modes, and stores a frame per channel in circular RAM. Readback uses logical addresses, where rd_addr = pre_depth is the trigger sample. It sits between the ADC front end and the display/readout logic, in one clock domain.

## Interface
- CH, 2: channel count (1..8)
- DW, 8: sample width
- AW, 10: address width; DEPTH = 2^AW samples per channel
- DECW, 10: decimation counter width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ad_valid  in  1  ad_data holds a new sample set
- ad_data  in  CH*DW  channel c at [c*DW +: DW]
- wave_run  in  1  capture enable
- trig_mode  in  2  0 auto, 1 normal, 2 single, 3 treated as normal
- trig_src  in  $clog2(CH) (min 1)  trigger channel; values ≥ CH select channel 0
- trig_level  in  DW  unsigned trigger threshold
- trig_edge  in  1  0 rising, 1 falling
- pre_depth  in  AW  pre-trigger samples; clamped to DEPTH-1
- deci_rate  in  DECW  keep 1 of every deci_rate valid samples; 0 is treated as 1
- auto_timeout  in  24  auto-mode timeout in decimated samples
- rd_en, rd_ch, rd_addr  in  1, $clog2(CH), AW  readback request, channel, logical address
- rd_data  out  DW  readback sample
- rd_done  in  1  single-cycle pulse: frame consumed, release buffer
- armed, triggered, capture_done, auto_trig  out  1 each  status

## Operation
- Decimator: counter over ad_valid. Decimation enable (de) fires on the first valid after arming, then every deci_rate-th valid.
- Each de cycle writes all CH channels at wr_ptr, then wr_ptr increments mod DEPTH.
- Arming is entry to PRE. On arming, mode, src, level, edge, clamped pre_depth, deci_rate and timeout are latched. The decimation counter, wr_ptr, prev-valid flag and timeout counter clear.
- States and transitions:
  - IDLE: wait for wave_run=1. For single mode, a 0→1 edge of wave_run is required after the previous single capture. Then go to PRE.
  - PRE: write pre_depth samples, then go to ARMED. Go directly to ARMED if pre_depth=0.
  - ARMED: keep writing circularly while checking for the trigger.
  - POST: write DEPTH-pre_depth samples. The trigger sample is the first of these.
  - DONE: hold the buffer. On rd_done, go to PRE if wave_run=1 and mode≠single, otherwise go to IDLE.
- Trigger check, on de in ARMED, using the latched channel:
  - rising: prev<level && cur≥level
  - falling: prev≥level && cur<level
  - Requires prev-valid. prev updates on every de.
- Auto mode: the timeout counter counts de cycles in ARMED. A trigger is forced on the de where the count equals auto_timeout, and auto_trig is set. auto_timeout=0 forces the trigger on the first de in ARMED.
- trig_ptr is wr_ptr of the trigger sample.
- Physical read address = (trig_ptr − pre_depth + rd_addr) mod DEPTH.
- wave_run=0 in PRE, ARMED or POST: go to IDLE next cycle; buffer contents are undefined. In DONE, the frame is held until rd_done.
- rd_done outside DONE is ignored. ad_valid in the rd_done cycle is not written.
- rd_ch ≥ CH reads channel 0.

## Timing
- Reset values: state IDLE; all status outputs 0; rd_data 0; wr_ptr 0; prev-valid 0.
- armed=1 in PRE and ARMED.
- triggered rises the cycle after the trigger de and stays 1 through POST and DONE.
- capture_done=1 exactly in DONE. It rises the cycle after the last POST write and clears the cycle after rd_done.
- auto_trig clears on arming.
- Write occurs on the same edge as the de cycle. Trigger detection is combinational on the incoming sample; the state is POST on the next cycle.
- rd_data is registered: data appears 1 cycle after rd_en and holds when rd_en=0. Reads are valid only in DONE.
- Maximum sustained input rate: ad_valid every cycle.

## Test plan
- Setup for the first two scenarios: CH=2, DEPTH=1024, auto mode, deci_rate=1, pre_depth=0, rising edge, level=128, ch0 sawtooth 0..255 step 1. Expected: trigger at sample value 128; read rd_addr=0 gives 128; rd_addr=1023 gives (128+1023) mod 256 = 127; capture_done after 1024 writes.
- Same setup with pre_depth=100. Expected: rd_addr=100 gives 128; rd_addr=99 gives 127; rd_addr=0 gives 28.
- Normal mode, constant input 50, level 128: no trigger, capture_done stays 0. Auto mode with timeout=500 on the same input: auto_trig=1 and capture_done after 500+1024 decimated samples.
- deci_rate=4, falling edge, trig_src=1, ch1 square wave, 8 samples high / 8 low, values 200/20. Expected: stored ch1 is 2 samples per level; the trigger sample (rd_addr=pre_depth) is 20 and the previous one is 200; ch0 is written in lockstep.
- Single mode: after one capture and rd_done, the block is in IDLE with wave_run still 1. Toggling wave_run 0→1 re-arms it; armed=1 the next cycle.
- Reset pulse in POST: all outputs return to 0 the next cycle. wave_run=0 in ARMED: IDLE next cycle, armed=0. rd_done in the same cycle as ad_valid: that sample is not written.
